mips_test_sequencer: RTL and testbench

- Synthesisable self-checking test controller for the pipelined MIPS32 core; replaces ad-hoc bench preloading and $display result inspection.
- Streams (address, data) words into core memory, releases core, waits for HLT with timeout, reads back result locations and compares against expected values.
- Sits between a stimulus source (bench, ROM or UART bridge) and the core's memory/control side; one clock domain.

---
 rtl/mips_test_pkg.sv | 22 ++
 rtl/mips_test_checker.sv | 61 ++++++
 rtl/mips_test_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_mips_test_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_test_pkg.sv
// Shared types and default sizing for the MIPS32 self-checking test sequencer.
package mips_test_pkg;

  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_ADDR_W         = 10;
  localparam int unsigned DEF_TIMEOUT_W      = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W          = 8;

  // Opcode field of the core's HLT instruction (bits 31:26)
  localparam logic [5:0] HLT_OPCODE = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CHECK_RD,
    ST_CHECK_CMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mips_test_checker.sv
// Read-back comparator: compares memory data against the latched expectation one
// cycle after the read strobe; keeps a saturating miss count and first-miss address.
module mips_test_checker
  import mips_test_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              chk_acc,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_expect,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cmp_valid_c,
  output logic              any_fail_c,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cmp_q;
  logic              mismatch_c;

  assign cmp_valid_c = cmp_q;
  assign mismatch_c  = cmp_q && (mem_rdata != exp_q);
  assign any_fail_c  = (fail_count != '0) || mismatch_c;

  // Entry latch and read-data alignment; the next entry can only be accepted in the compare cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  <= '0;
      addr_q <= '0;
      cmp_q  <= 1'b0;
    end else begin
      cmp_q <= rd_issue;
      if (chk_acc) begin
        exp_q  <= chk_expect;
        addr_q <= chk_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_count      <= '0;
      first_fail_addr <= '0;
    end else if (clear) begin
      fail_count      <= '0;
      first_fail_addr <= '0;
    end else if (mismatch_c) begin
      if (fail_count != {CNT_W{1'b1}}) fail_count <= fail_count + CNT_W'(1);
      if (fail_count == '0)            first_fail_addr <= addr_q;
    end
  end

endmodule

// File: rtl/mips_test_sequencer.sv
// Self-checking test controller: load core memory, run core until HLT or timeout,
// read back and compare results. Optional RUN cycle counter under CYCLE_COUNT_EN.
module mips_test_sequencer
  import mips_test_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_W      = DEF_TIMEOUT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 ld_last,
  input  logic                 chk_valid,
  output logic                 chk_ready,
  input  logic [ADDR_W-1:0]    chk_addr,
  input  logic [DATA_W-1:0]    chk_expect,
  input  logic                 chk_last,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_re,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 core_hold,
  input  logic                 core_halted,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
`ifdef CYCLE_COUNT_EN
  output logic [TIMEOUT_W-1:0] run_cycles,
`endif
  output logic [CNT_W-1:0]     fail_count,
  output logic [ADDR_W-1:0]    first_fail_addr
);

  state_e                state_q, state_d;
  logic [TIMEOUT_W-1:0]  timer_q, timer_d;
  logic                  last_q, last_d;
  logic                  ld_ready_d, chk_ready_d, mem_we_d, mem_re_d, core_hold_d;
  logic                  busy_d, done_d, pass_d, timeout_d;
  logic [ADDR_W-1:0]     mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_d;
  logic                  clear_c, ld_acc_c, chk_acc_c, cmp_valid_c, any_fail_c;

  assign ld_acc_c  = (state_q == ST_LOAD) && ld_valid && ld_ready;
  assign chk_acc_c = (state_q == ST_CHECK_RD) && chk_valid && chk_ready;

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    last_d      = last_q;
    ld_ready_d  = 1'b0;
    chk_ready_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    core_hold_d = 1'b1;
    done_d      = done;
    pass_d      = pass;
    timeout_d   = timeout;
    clear_c     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          clear_c    = 1'b1;
          ld_ready_d = 1'b1;
        end
      end
      ST_LOAD: begin
        ld_ready_d = 1'b1;
        if (ld_acc_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_data;
          // Core is released in the same cycle the final write is issued
          if (ld_last) begin
            state_d     = ST_RUN;
            ld_ready_d  = 1'b0;
            timer_d     = '0;
            core_hold_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        core_hold_d = 1'b0;
        timer_d     = timer_q + TIMEOUT_W'(1);
        if (core_halted) begin
          state_d     = ST_CHECK_RD;
          core_hold_d = 1'b1;
          chk_ready_d = 1'b1;
        end else if (timer_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_CHECK_RD;
          core_hold_d = 1'b1;
          chk_ready_d = 1'b1;
          timeout_d   = 1'b1;
        end
      end
      ST_CHECK_RD: begin
        chk_ready_d = 1'b1;
        if (chk_acc_c) begin
          state_d     = ST_CHECK_CMP;
          chk_ready_d = 1'b0;
          mem_re_d    = 1'b1;
          mem_addr_d  = chk_addr;
          last_d      = chk_last;
        end
      end
      ST_CHECK_CMP: begin
        // Non-final compares overlap the next read; the final one is awaited before DONE
        if (!last_q) begin
          state_d     = ST_CHECK_RD;
          chk_ready_d = 1'b1;
        end else if (cmp_valid_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = !any_fail_c && !timeout;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      last_q    <= 1'b0;
      ld_ready  <= 1'b0;
      chk_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_hold <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      ld_ready  <= ld_ready_d;
      chk_ready <= chk_ready_d;
      mem_we    <= mem_we_d;
      mem_re    <= mem_re_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      core_hold <= core_hold_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      timeout   <= timeout_d;
    end
  end

`ifdef CYCLE_COUNT_EN
  logic run_exit_c;
  assign run_exit_c = (state_q == ST_RUN) && (state_d != ST_RUN);

  // Number of RUN cycles, captured on leaving RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          run_cycles <= '0;
    else if (clear_c)    run_cycles <= '0;
    else if (run_exit_c) run_cycles <= timer_q + TIMEOUT_W'(1);
  end
`endif

  mips_test_checker #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_checker (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear_c),
    .chk_acc         (chk_acc_c),
    .chk_addr        (chk_addr),
    .chk_expect      (chk_expect),
    .rd_issue        (mem_re),
    .mem_rdata       (mem_rdata),
    .cmp_valid_c     (cmp_valid_c),
    .any_fail_c      (any_fail_c),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr)
  );

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer: memory model plus a scripted stand-in for the core
// (performs the program's SW result and raises HALTED), table-driven scenarios.
module tb_mips_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0, ld_ready, ld_last = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        chk_valid = 1'b0, chk_ready, chk_last = 1'b0;
  logic [9:0]  chk_addr = '0;
  logic [31:0] chk_expect = '0;
  logic        mem_we, mem_re;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        core_hold, core_halted = 1'b0;
  logic        busy, done, pass, timeout;
  logic [7:0]  fail_count;
  logic [9:0]  first_fail_addr;
`ifdef CYCLE_COUNT_EN
  logic [15:0] run_cycles;
`endif

  mips_test_sequencer #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_addr(chk_addr), .chk_expect(chk_expect),
    .chk_last(chk_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .core_hold(core_hold), .core_halted(core_halted),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
`ifdef CYCLE_COUNT_EN
    .run_cycles(run_cycles),
`endif
    .fail_count(fail_count), .first_fail_addr(first_fail_addr)
  );

  always #5 clk = ~clk;

  // Core memory model with a write log; core_we stands in for the core's own SW
  logic [31:0] mem [1024];
  logic        core_we = 1'b0;
  logic [9:0]  core_waddr = '0;
  logic [31:0] core_wdata = '0;
  logic [9:0]  we_addr_log [256];
  logic [31:0] we_data_log [256];
  logic [7:0]  wptr = '0;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      we_addr_log[wptr] <= mem_addr;
      we_data_log[wptr] <= mem_wdata;
      wptr              <= wptr + 8'd1;
      we_cnt            <= we_cnt + 1;
    end
    if (core_we) mem[core_waddr] <= core_wdata;
    if (mem_re)  mem_rdata <= mem[mem_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [9:0]  la [9];
  logic [31:0] ldat [9];
  logic [9:0]  ca [512];
  logic [31:0] ce [512];

  task automatic load_words(input int n, input bit gap);
    int i = 0;
    int g = 0;
    while (i < n && g < 200) begin
      @(negedge clk);
      g++;
      if (gap && (g % 2 == 0)) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_addr  = la[i];
        ld_data  = ldat[i];
        ld_last  = (i == n - 1);
        if (ld_ready) i++;
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (i < n) check("load_handshake", 32'(i), 32'(n));
  endtask

  // Waits for release, then optionally performs Mem[121] = Mem[120] + 45 and halts
  task automatic run_core(input bit halt);
    int g = 0;
    while (core_hold && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("core_released", 32'(core_hold), 32'(0));
    if (halt) begin
      repeat (6) @(negedge clk);
      core_we    = 1'b1;
      core_waddr = 10'd121;
      core_wdata = mem[10'd120] + 32'd45;
      @(negedge clk);
      core_we     = 1'b0;
      core_halted = 1'b1;
    end
  endtask

  task automatic send_checks(input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 3000) begin
      @(negedge clk);
      g++;
      chk_valid  = 1'b1;
      chk_addr   = ca[i];
      chk_expect = ce[i];
      chk_last   = (i == n - 1);
      if (chk_ready) i++;
    end
    @(negedge clk);
    chk_valid = 1'b0;
    chk_last  = 1'b0;
    if (i < n) check("check_handshake", 32'(i), 32'(n));
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic run_scenario(input bit halt, input int nchk, input bit gap, input int nload);
    @(negedge clk);
    core_halted = 1'b0;
    core_we     = 1'b1;
    core_waddr  = 10'd121;
    core_wdata  = 32'd0;
    @(negedge clk);
    core_we = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_words(nload, gap);
    run_core(halt);
    send_checks(nchk);
    wait_done();
  endtask

  task automatic check_end(input string tag, input bit e_pass, input bit e_to,
                           input logic [7:0] e_fail, input logic [9:0] e_ffa);
    check({tag, ".done"},      32'(done),            32'(1));
    check({tag, ".pass"},      32'(pass),            32'(e_pass));
    check({tag, ".timeout"},   32'(timeout),         32'(e_to));
    check({tag, ".fail_cnt"},  32'(fail_count),      32'(e_fail));
    check({tag, ".first_ffa"}, 32'(first_fail_addr), 32'(e_ffa));
    check({tag, ".core_hold"}, 32'(core_hold),       32'(1));
    check({tag, ".busy"},      32'(busy),            32'(0));
  endtask

  typedef struct {
    bit          halt;
    int          nchk;
    logic [9:0]  a0;
    logic [31:0] e0;
    logic [9:0]  a1;
    logic [31:0] e1;
    bit          e_pass;
    bit          e_to;
    logic [7:0]  e_fail;
    logic [9:0]  e_ffa;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    int base;
    // ADDI R1,R0,120; OR; LW R2,0(R1); OR; ADDI R2,R2,45; OR; SW R2,1(R1); HLT; Mem[120]=85
    ldat[0] = 32'h2801_0078; ldat[1] = 32'h0c63_1800; ldat[2] = 32'h2022_0000;
    ldat[3] = 32'h0c63_1800; ldat[4] = 32'h2842_002d; ldat[5] = 32'h0c63_1800;
    ldat[6] = 32'h2422_0001; ldat[7] = 32'hfc00_0000; ldat[8] = 32'd85;
    for (int i = 0; i < 8; i++) la[i] = 10'(i);
    la[8] = 10'd120;

    //          halt nchk a0    e0   a1    e1   pass to fail ffa
    vecs[0] = '{1'b1, 1, 10'd121, 130, 10'd0,   0,  1'b1, 1'b0, 8'd0, 10'd0};
    vecs[1] = '{1'b1, 2, 10'd121, 131, 10'd120, 85, 1'b0, 1'b0, 8'd1, 10'd121};
    vecs[2] = '{1'b0, 1, 10'd121, 0,   10'd0,   0,  1'b0, 1'b1, 8'd0, 10'd0};
    vecs[3] = '{1'b0, 2, 10'd121, 130, 10'd120, 85, 1'b0, 1'b1, 8'd1, 10'd121};
    vecs[4] = '{1'b1, 2, 10'd120, 85,  10'd121, 130, 1'b1, 1'b0, 8'd0, 10'd0};
    vecs[5] = '{1'b1, 2, 10'd120, 99,  10'd121, 7,  1'b0, 1'b0, 8'd2, 10'd120};

    repeat (2) @(negedge clk);
    check("rst.core_hold", 32'(core_hold),       32'(1));
    check("rst.mem_we",    32'(mem_we),          32'(0));
    check("rst.mem_re",    32'(mem_re),          32'(0));
    check("rst.ld_ready",  32'(ld_ready),        32'(0));
    check("rst.chk_ready", 32'(chk_ready),       32'(0));
    check("rst.busy",      32'(busy),            32'(0));
    check("rst.done",      32'(done),            32'(0));
    check("rst.pass",      32'(pass),            32'(0));
    check("rst.timeout",   32'(timeout),         32'(0));
    check("rst.fail_cnt",  32'(fail_count),      32'(0));
    check("rst.ffa",       32'(first_fail_addr), 32'(0));
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      ca[0] = vecs[v].a0; ce[0] = vecs[v].e0;
      ca[1] = vecs[v].a1; ce[1] = vecs[v].e1;
      run_scenario(vecs[v].halt, vecs[v].nchk, 1'b0, 9);
      check_end($sformatf("vec%0d", v), vecs[v].e_pass, vecs[v].e_to, vecs[v].e_fail, vecs[v].e_ffa);
    end

    // Exact timeout timing, with an ignored start pulse mid-RUN
    @(negedge clk);
    core_halted = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("to.busy", 32'(busy), 32'(1));
    load_words(9, 1'b0);
    n = 0;
    while (!timeout && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == 10);
    end
    start = 1'b0;
    check("to.cycles",    32'(n),         32'(50));
    check("to.core_hold", 32'(core_hold), 32'(1));
    check("to.done",      32'(done),      32'(0));
    check("to.busy",      32'(busy),      32'(1));
`ifdef CYCLE_COUNT_EN
    check("to.run_cycles", 32'(run_cycles), 32'(50));
`endif
    ca[0] = 10'd120; ce[0] = 32'd85;
    send_checks(1);
    wait_done();
    check_end("to", 1'b0, 1'b1, 8'd0, 10'd0);

    // Backpressured load of the 8 program words
    base = we_cnt;
    ca[0] = 10'd121; ce[0] = 32'd130;
    run_scenario(1'b1, 1, 1'b1, 8);
    check("bp.we_count", 32'(we_cnt - base), 32'(8));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bp.addr%0d", k), 32'(we_addr_log[8'(base + k)]), 32'(k));
      check($sformatf("bp.data%0d", k), we_data_log[8'(base + k)], ldat[k]);
    end
    check_end("bp", 1'b1, 1'b0, 8'd0, 10'd0);

    // Asynchronous reset during RUN, then a clean rerun
    @(negedge clk);
    core_halted = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_words(9, 1'b0);
    run_core(1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.core_hold", 32'(core_hold), 32'(1));
    check("arst.done",      32'(done),      32'(0));
    check("arst.busy",      32'(busy),      32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ca[0] = 10'd121; ce[0] = 32'd130;
    run_scenario(1'b1, 1, 1'b0, 9);
    check_end("arst", 1'b1, 1'b0, 8'd0, 10'd0);

    // 300 mismatching checks: counter saturates, first address retained
    for (int i = 0; i < 300; i++) begin
      ca[i] = 10'(7 - (i % 8));
      ce[i] = ldat[7 - (i % 8)] + 32'd1;
    end
    run_scenario(1'b1, 300, 1'b0, 9);
    check_end("sat", 1'b0, 1'b0, 8'd255, 10'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
